mips_fetch_ctrl: RTL and testbench
==================================

MIPS_FETCH_CTRL -- requirements
Module: mips_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 30'h0, giving the word address fetched first after reset.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the fetch watchdog limit (used only with REQ-024).
REQ-003 The block SHALL have one clock, clk, and one reset, reset, which is asynchronous and active-low.
REQ-004 The block SHALL have the following ports.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous active-low reset.
- stall  in  1  consumer cannot take ir this cycle.
- branch, confirm_br, jump  in  1 each  redirect controls for the instruction in ir; valid only when ir_valid=1.
- imm16  in  16  branch offset in words.
- imm26  in  26  jump target field.
- mem_req  out  1  instruction-memory request.
- mem_addr  out  32  byte address {fpc,2'b00}.
- mem_ready  in  1  memory accepts and returns data this cycle.
- mem_rdata  in  32  instruction word, valid with mem_ready.
- ir  out  32  current instruction.
- ir_valid  out  1  ir holds a live instruction.
- pc  out  32  byte address of ir, {pc_w,2'b00}.
- fetch_err  out  1  watchdog pulse.

Function
REQ-005 Consume event C SHALL be ir_valid && !stall; redirect event R SHALL be C && (jump || (branch && confirm_br)).
REQ-006 Redirect target SHALL be {pc_w[29:26],imm26} when jump=1, otherwise pc_w+1+sign-extended imm16, both modulo 2^30; jump wins when both fire.
REQ-007 Without redirect, next fetch address SHALL be fpc+1 modulo 2^30 (30'h3FFFFFFF wraps to 0).
REQ-008 The FSM SHALL have states IDLE, FETCH, FULL and SQUASH.
- IDLE: mem_req=0 for exactly one cycle after reset, then FETCH.
- FETCH: mem_req=1.
- FULL: ir and prefetch buffer both valid, mem_req=0.
- SQUASH: mem_req=1 with a stale address, and the returned word is discarded.
REQ-009 mem_req and mem_addr SHALL stay stable from assertion until the cycle mem_ready=1, and a request SHALL never be withdrawn early.
REQ-010 In FETCH, if mem_ready=1 and there is no R, the word SHALL go to ir when ir is empty or consumed with the buffer empty. Otherwise it SHALL go to the buffer. pc_w follows the word that lands in ir, and fpc advances per REQ-007.
REQ-011 In FETCH, when mem_ready=1 leaves ir and the buffer both valid, the FSM SHALL enter FULL.
REQ-012 On C with the buffer valid, ir SHALL load the buffer contents the next cycle, with no bubble.
REQ-013 In FULL, on C without R, ir SHALL take the buffer and the FSM SHALL return to FETCH.
REQ-014 On R, ir_valid and the buffer SHALL clear the next cycle and fpc SHALL load the target.
REQ-015 On R, the next state SHALL be FETCH if no request is outstanding or mem_ready=1 that cycle (that word is dropped), and SQUASH otherwise.
REQ-016 In SQUASH, on mem_ready=1 the data SHALL be discarded and the FSM SHALL go to FETCH at the target address.
REQ-017 A redirect arriving in SQUASH SHALL overwrite the target and the FSM SHALL stay in SQUASH.
REQ-018 Throughput SHALL be one instruction per cycle when mem_ready=1 continuously and stall=0.
REQ-019 Latency SHALL be: first ir_valid no earlier than 2 cycles after reset deassertion, and the first target word no earlier than 1 cycle after R when mem_ready=1.

Reset
REQ-020 Reset assertion SHALL, at any time including mid-request, force IDLE, mem_req=0, ir_valid=0, buffer invalid, fetch_err=0, ir=0, pc_w=RESET_PC and fpc=RESET_PC.
REQ-021 A memory response arriving during reset SHALL be ignored.

Configuration
REQ-022 The fetch watchdog SHALL be controlled by the macro IFU_FETCH_TIMEOUT_EN.
REQ-023 Without IFU_FETCH_TIMEOUT_EN, fetch_err SHALL be constant 0 and no counter SHALL exist.
REQ-024 With IFU_FETCH_TIMEOUT_EN, a counter SHALL count cycles with mem_req=1 and mem_ready=0, and clear on mem_ready or a state change. When it reaches TIMEOUT_CYCLES, fetch_err SHALL pulse for one cycle, the counter SHALL restart, and the request SHALL be held.

Structure
REQ-025 Package mips_fetch_pkg SHALL hold the FSM state enum, the PC width constant (30) and the default RESET_PC.
REQ-026 Target computation SHALL be a combinational sub-module mips_npc_calc with inputs pc_w, imm16, imm26 and jump, and output the target.

Verification
REQ-027 The bench SHALL cover these directed scenarios.
- Reset release, mem_ready=1 always, stall=0 -> mem_addr 0,4,8,... ir_valid from cycle 2, one instruction per cycle.
- stall=1 for 3 cycles, mem_ready=1 -> FULL entered, mem_req=0, ir stable; on release ir advances with no gap.
- pc=0x100, branch=confirm_br=1, imm16=16'hFFFE -> next mem_addr 0xFC, prefetched 0x104 dropped.
- pc=0x2000_0040, jump=1, imm26=26'h10 -> target 0x2000_0040; branch=1 at the same time is ignored.
- Redirect while mem_ready=0 for 4 cycles -> SQUASH holds the old address, the returned word never reaches ir, then the target is fetched.
- With IFU_FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_ready=0 -> fetch_err pulses at 16 and 32 waiting cycles, mem_addr unchanged; reset mid-wait -> IDLE, mem_req=0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared fetch-unit types and constants.
// Imported by mips_fetch_ctrl and mips_npc_calc.
package mips_fetch_pkg;

  localparam int PC_W = 30;

  localparam logic [PC_W-1:0] DEF_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL,
    SQUASH
  } fstate_t;

endpackage

// File: rtl/mips_npc_calc.sv
// Redirect target: jump region target or pc+1+simm16.
// Purely combinational, word addresses modulo 2^30.
module mips_npc_calc
  import mips_fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc_w,
  input  logic [15:0]     imm16,
  input  logic [25:0]     imm26,
  input  logic            jump,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] sext;

  assign sext = {{(PC_W-16){imm16[15]}}, imm16};

  // jump takes priority over a confirmed branch
  always_comb begin
    if (jump)
      target = {pc_w[29:26], imm26};
    else
      target = pc_w + PC_W'(1) + sext;
  end

endmodule

// File: rtl/mips_fetch_ctrl.sv
// Instruction fetch control: ir plus one prefetch buffer.
// Optional watchdog via macro IFU_FETCH_TIMEOUT_EN.
module mips_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        confirm_br,
  input  logic        jump,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic        fetch_err
);

  fstate_t state_q, state_d;
  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [PC_W-1:0] pcw_q, pcw_d;
  logic [PC_W-1:0] ppc_q, ppc_d;
  logic [PC_W-1:0] sq_q, sq_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pbuf_q, pbuf_d;
  logic irv_q, irv_d;
  logic pbv_q, pbv_d;
  logic consume, redir;
  logic [PC_W-1:0] target;

  mips_npc_calc u_npc (
    .pc_w   (pcw_q),
    .imm16  (imm16),
    .imm26  (imm26),
    .jump   (jump),
    .target (target)
  );

  assign consume = irv_q && !stall;
  assign redir = consume && (jump || (branch && confirm_br));

  assign mem_req = (state_q == FETCH) || (state_q == SQUASH);
  assign mem_addr = {(state_q == SQUASH) ? sq_q : fpc_q, 2'b00};
  assign ir = ir_q;
  assign ir_valid = irv_q;
  assign pc = {pcw_q, 2'b00};

  // next-state and datapath steering
  always_comb begin
    state_d = state_q;
    fpc_d = fpc_q;
    pcw_d = pcw_q;
    ppc_d = ppc_q;
    sq_d = sq_q;
    ir_d = ir_q;
    pbuf_d = pbuf_q;
    irv_d = irv_q;
    pbv_d = pbv_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redir) begin
          irv_d = 1'b0;
          pbv_d = 1'b0;
          fpc_d = target;
          sq_d = fpc_q;
          state_d = mem_ready ? FETCH : SQUASH;
        end else begin
          if (consume) begin
            if (pbv_q) begin
              ir_d = pbuf_q;
              pcw_d = ppc_q;
              pbv_d = 1'b0;
            end else begin
              irv_d = 1'b0;
            end
          end
          if (mem_ready) begin
            fpc_d = fpc_q + PC_W'(1);
            if (!irv_q || (consume && !pbv_q)) begin
              ir_d = mem_rdata;
              pcw_d = fpc_q;
              irv_d = 1'b1;
            end else begin
              pbuf_d = mem_rdata;
              ppc_d = fpc_q;
              pbv_d = 1'b1;
            end
            if (irv_d && pbv_d)
              state_d = FULL;
          end
        end
      end
      FULL: begin
        if (redir) begin
          irv_d = 1'b0;
          pbv_d = 1'b0;
          fpc_d = target;
          state_d = FETCH;
        end else if (consume) begin
          ir_d = pbuf_q;
          pcw_d = ppc_q;
          pbv_d = 1'b0;
          state_d = FETCH;
        end
      end
      SQUASH: begin
        if (redir) begin
          irv_d = 1'b0;
          pbv_d = 1'b0;
          fpc_d = target;
        end
        if (mem_ready)
          state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fpc_q <= RESET_PC;
      pcw_q <= RESET_PC;
      ppc_q <= RESET_PC;
      sq_q <= RESET_PC;
      ir_q <= '0;
      pbuf_q <= '0;
      irv_q <= 1'b0;
      pbv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
      pcw_q <= pcw_d;
      ppc_q <= ppc_d;
      sq_q <= sq_d;
      ir_q <= ir_d;
      pbuf_q <= pbuf_d;
      irv_q <= irv_d;
      pbv_q <= pbv_d;
    end
  end

`ifdef IFU_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_q;
  logic err_q;

  // count stalled request cycles; pulse and restart at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (mem_ready || (state_d != state_q)) begin
        wd_q <= '0;
      end else if (mem_req) begin
        if (wd_q == CW'(TIMEOUT_CYCLES - 1)) begin
          wd_q <= '0;
          err_q <= 1'b1;
        end else begin
          wd_q <= wd_q + CW'(1);
        end
      end
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_fetch_ctrl.sv
// Directed bench for mips_fetch_ctrl.
// Define IFU_FETCH_TIMEOUT_EN to exercise the watchdog.
module tb_mips_fetch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall, branch, confirm_br, jump;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic mem_req, mem_ready;
  logic [31:0] mem_addr, mem_rdata, ir, pc;
  logic ir_valid, fetch_err;

  logic reset2 = 1'b0;
  logic stall2, branch2, confirm2, jump2;
  logic [15:0] imm16_2;
  logic [25:0] imm26_2;
  logic req2, rdy2;
  logic [31:0] addr2, rdata2, ir2, pc2;
  logic irv2, err2;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ KEY;
  assign rdata2 = addr2 ^ KEY;

  mips_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .branch     (branch),
    .confirm_br (confirm_br),
    .jump       (jump),
    .imm16      (imm16),
    .imm26      (imm26),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .fetch_err  (fetch_err)
  );

  mips_fetch_ctrl #(.RESET_PC(30'h0800_0010)) dut2 (
    .clk        (clk),
    .reset      (reset2),
    .stall      (stall2),
    .branch     (branch2),
    .confirm_br (confirm2),
    .jump       (jump2),
    .imm16      (imm16_2),
    .imm26      (imm26_2),
    .mem_req    (req2),
    .mem_addr   (addr2),
    .mem_ready  (rdy2),
    .mem_rdata  (rdata2),
    .ir         (ir2),
    .ir_valid   (irv2),
    .pc         (pc2),
    .fetch_err  (err2)
  );

  typedef struct packed {
    logic        stall;
    logic        br;
    logic        cf;
    logic        jp;
    logic [15:0] i16;
    logic [25:0] i26;
    logic        rdy;
    logic        req;
    logic        ca;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[21];

  function automatic vec_t mk(
    input logic s, input logic b, input logic c, input logic j,
    input logic [15:0] i16, input logic [25:0] i26, input logic r,
    input logic q, input logic ca, input logic [31:0] a,
    input logic v, input logic [31:0] p);
    vec_t t;
    t = '{s, b, c, j, i16, i26, r, q, ca, a, v, p};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL sim_timeout act=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    stall = 0; branch = 0; confirm_br = 0; jump = 0;
    imm16 = '0; imm26 = '0; mem_ready = 1'b1;
    stall2 = 0; branch2 = 0; confirm2 = 0; jump2 = 0;
    imm16_2 = '0; imm26_2 = '0; rdy2 = 1'b1;

    tv[0]  = mk(0,0,0,0,16'h0,26'h0,1, 0,1,32'h000,0,32'h0);
    tv[1]  = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h000,0,32'h0);
    tv[2]  = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h004,1,32'h000);
    tv[3]  = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h008,1,32'h004);
    tv[4]  = mk(1,0,0,0,16'h0,26'h0,1, 1,1,32'h00C,1,32'h008);
    tv[5]  = mk(1,0,0,0,16'h0,26'h0,1, 0,0,32'h000,1,32'h008);
    tv[6]  = mk(1,0,0,0,16'h0,26'h0,1, 0,0,32'h000,1,32'h008);
    tv[7]  = mk(0,0,0,0,16'h0,26'h0,1, 0,0,32'h000,1,32'h008);
    tv[8]  = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h010,1,32'h00C);
    tv[9]  = mk(0,0,0,1,16'h0,26'h40,1, 1,1,32'h014,1,32'h010);
    tv[10] = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h100,0,32'h0);
    tv[11] = mk(0,1,1,0,16'hFFFE,26'h0,1, 1,1,32'h104,1,32'h100);
    tv[12] = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h0FC,0,32'h0);
    tv[13] = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h100,1,32'h0FC);
    tv[14] = mk(0,0,0,1,16'h0,26'h80,0, 1,1,32'h104,1,32'h100);
    tv[15] = mk(0,0,0,0,16'h0,26'h0,0, 1,1,32'h104,0,32'h0);
    tv[16] = mk(0,0,0,0,16'h0,26'h0,0, 1,1,32'h104,0,32'h0);
    tv[17] = mk(0,0,0,0,16'h0,26'h0,0, 1,1,32'h104,0,32'h0);
    tv[18] = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h104,0,32'h0);
    tv[19] = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h200,0,32'h0);
    tv[20] = mk(0,0,0,0,16'h0,26'h0,1, 1,1,32'h204,1,32'h200);

    repeat (3) @(negedge clk);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_iv", ir_valid, 1'b0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk1("rst_err", fetch_err, 1'b0);
    chk("rst2_pc", pc2, 32'h2000_0040);

    reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      stall = tv[i].stall;
      branch = tv[i].br;
      confirm_br = tv[i].cf;
      jump = tv[i].jp;
      imm16 = tv[i].i16;
      imm26 = tv[i].i26;
      mem_ready = tv[i].rdy;
      #1;
      chk1($sformatf("req[%0d]", i), mem_req, tv[i].req);
      if (tv[i].ca)
        chk($sformatf("addr[%0d]", i), mem_addr, tv[i].addr);
      chk1($sformatf("iv[%0d]", i), ir_valid, tv[i].iv);
      chk1($sformatf("err[%0d]", i), fetch_err, 1'b0);
      if (tv[i].iv) begin
        chk($sformatf("pc[%0d]", i), pc, tv[i].pc);
        chk($sformatf("ir[%0d]", i), ir, tv[i].pc ^ KEY);
      end
      @(negedge clk);
    end

    stall = 0; branch = 0; confirm_br = 0; jump = 0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk1("mid_req", mem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("mid_rst_req", mem_req, 1'b0);
    chk1("mid_rst_iv", ir_valid, 1'b0);
    chk("mid_rst_ir", ir, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("rst_resp_iv", ir_valid, 1'b0);
    chk1("rst_resp_req", mem_req, 1'b0);
    reset = 1'b1;
    #1;
    chk1("idle_req", mem_req, 1'b0);
    @(negedge clk);
    chk1("refetch_req", mem_req, 1'b1);
    chk("refetch_addr", mem_addr, 32'h0);

    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      #1;
`ifdef IFU_FETCH_TIMEOUT_EN
      chk1($sformatf("wd_err[%0d]", k), fetch_err,
           (k == 17) || (k == 33));
`else
      chk1($sformatf("wd_err[%0d]", k), fetch_err, 1'b0);
`endif
      if (k >= 1) begin
        chk1($sformatf("wd_req[%0d]", k), mem_req, 1'b1);
        chk($sformatf("wd_addr[%0d]", k), mem_addr, 32'h0);
      end
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    chk1("wd_rst_req", mem_req, 1'b0);
    chk1("wd_rst_err", fetch_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk1("wd_idle_req", mem_req, 1'b0);

    @(negedge clk);
    reset2 = 1'b1;
    #1;
    chk1("j_idle_req", req2, 1'b0);
    @(negedge clk);
    #1;
    chk("j_addr0", addr2, 32'h2000_0040);
    @(negedge clk);
    jump2 = 1'b1;
    branch2 = 1'b1;
    confirm2 = 1'b1;
    imm16_2 = 16'h0100;
    imm26_2 = 26'h10;
    #1;
    chk1("j_iv", irv2, 1'b1);
    chk("j_pc", pc2, 32'h2000_0040);
    chk("j_addr1", addr2, 32'h2000_0044);
    @(negedge clk);
    jump2 = 1'b0;
    branch2 = 1'b0;
    confirm2 = 1'b0;
    #1;
    chk("j_tgt_addr", addr2, 32'h2000_0040);
    chk1("j_tgt_iv", irv2, 1'b0);
    @(negedge clk);
    #1;
    chk1("j_new_iv", irv2, 1'b1);
    chk("j_new_pc", pc2, 32'h2000_0040);
    chk("j_new_ir", ir2, 32'h2000_0040 ^ KEY);
    chk1("j_err", err2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
